// File: rtl/recorder_pkg.sv
// Shared types for the DUT response recorder: FSM states and the default
// event entry layout (timestamp above value).
package recorder_pkg;

  localparam int REC_DATA_WIDTH = 8;
  localparam int REC_TS_WIDTH   = 32;
  localparam int REC_DEPTH      = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RECORD = 2'd2
  } rec_state_t;

  // Entry layout at the default widths; the top level declares the same
  // layout locally so that it follows its own parameters.
  typedef struct packed {
    logic [REC_TS_WIDTH-1:0]   ts;
    logic [REC_DATA_WIDTH-1:0] value;
  } rec_entry_t;

endpackage

// File: rtl/recorder_fifo.sv
// Show-ahead synchronous FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart when the index bits match. A push while
// full is accepted only if a pop happens on the same edge.
module recorder_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dut_response_recorder.sv
// DUT response recorder: synchronises the DUT output bus into the hub clock
// domain, time-stamps every value change and buffers it for a reader.
//
// state  | meaning
// IDLE   | recording off, timestamp held at 0, nothing written
// ARMED  | one cycle; baseline {ts=0, value} written, last loaded
// RECORD | every change of the synchronised bus is written with its stamp
module dut_response_recorder
  import recorder_pkg::*;
#(
  parameter int DATA_WIDTH = REC_DATA_WIDTH,
  parameter int DEPTH      = REC_DEPTH,
  parameter int TS_WIDTH   = REC_TS_WIDTH
) (
  input  logic                    hub_clocks,
  input  logic                    hub_reset,
  input  logic                    enable,
  input  logic                    clear_overflow,
  input  logic [DATA_WIDTH-1:0]   dut_outputs,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_value,
  output logic [TS_WIDTH-1:0]     rd_timestamp,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [15:0]             drop_count
);

  typedef struct packed {
    logic [TS_WIDTH-1:0]   ts;
    logic [DATA_WIDTH-1:0] value;
  } entry_t;

  rec_state_t            state;
  rec_state_t            state_next;
  logic [DATA_WIDTH-1:0] sync1;
  logic [DATA_WIDTH-1:0] sync2;
  logic [DATA_WIDTH-1:0] last;
  logic [TS_WIDTH-1:0]   ts;
  logic                  push;
  logic                  load_last;
  logic                  pop;
  logic                  drop;
  logic                  full;
  logic                  empty;
  entry_t                wr_entry;
  entry_t                rd_entry;

  // Two-flop synchroniser on the asynchronous DUT bus.
  always_ff @(posedge hub_clocks or posedge hub_reset) begin
    if (hub_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= dut_outputs;
      sync2 <= sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge hub_clocks or posedge hub_reset) begin
    if (hub_reset) state <= IDLE;
    else           state <= state_next;
  end

  // Next state and event write request.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    load_last  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = ARMED;
      end
      ARMED: begin
        push       = 1'b1;
        load_last  = 1'b1;
        state_next = RECORD;
      end
      RECORD: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (sync2 != last) begin
          push      = 1'b1;
          load_last = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Previous value tracks every detected change, even a dropped one, so a
  // full buffer does not turn one change into a stream of repeats.
  always_ff @(posedge hub_clocks or posedge hub_reset) begin
    if (hub_reset)      last <= '0;
    else if (load_last) last <= sync2;
  end

  // Timestamp: 0 through IDLE and ARMED, then counts RECORD cycles, wrapping.
  always_ff @(posedge hub_clocks or posedge hub_reset) begin
    if (hub_reset)                ts <= '0;
    else if (state_next == RECORD) ts <= ts + 1'b1;
    else                          ts <= '0;
  end

  assign wr_entry.ts    = ts;
  assign wr_entry.value = sync2;
  assign rd_valid       = ~empty;
  assign pop            = rd_valid & rd_ready;
  assign drop           = push & full & ~pop;
  assign rd_value       = rd_valid ? rd_entry.value : '0;
  assign rd_timestamp   = rd_valid ? rd_entry.ts : '0;

  recorder_fifo #(
    .WIDTH (TS_WIDTH + DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (hub_clocks),
    .rst     (hub_reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Sticky overflow and saturating drop counter; a drop beats a clear.
  always_ff @(posedge hub_clocks or posedge hub_reset) begin
    if (hub_reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      overflow <= drop | (overflow & ~clear_overflow);
      if (clear_overflow)
        drop_count <= drop ? 16'd1 : 16'd0;
      else if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dut_response_recorder.sv
// Bench for dut_response_recorder: directed vectors push expected entries
// into queues; negedge monitors pop and compare whenever an entry is read.
module tb_dut_response_recorder;

  logic        hub_clocks = 1'b0;
  logic        hub_reset;

  // Instance 1: default parameters (DEPTH 16, TS_WIDTH 32).
  logic        enable, clear_overflow, rd_ready;
  logic [7:0]  dut_outputs;
  logic        rd_valid, overflow;
  logic [7:0]  rd_value;
  logic [31:0] rd_timestamp;
  logic [4:0]  count;
  logic [15:0] drop_count;

  // Instance 2: DEPTH 4, TS_WIDTH 4 for wrap and clear-vs-drop.
  logic        enable2, clear2, rd_ready2;
  logic [7:0]  dut2;
  logic        rd_valid2, overflow2;
  logic [7:0]  rd_value2;
  logic [3:0]  rd_timestamp2;
  logic [2:0]  count2;
  logic [15:0] drop_count2;

  int n_checks = 0;
  int n_fail   = 0;
  int en_ticks = 0;

  logic [39:0] exp_q[$];
  logic [11:0] exp2_q[$];

  always #5 hub_clocks = ~hub_clocks;

  dut_response_recorder u_dut (
    .hub_clocks     (hub_clocks),
    .hub_reset      (hub_reset),
    .enable         (enable),
    .clear_overflow (clear_overflow),
    .dut_outputs    (dut_outputs),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_value       (rd_value),
    .rd_timestamp   (rd_timestamp),
    .count          (count),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  dut_response_recorder #(.DATA_WIDTH(8), .DEPTH(4), .TS_WIDTH(4)) u_dut2 (
    .hub_clocks     (hub_clocks),
    .hub_reset      (hub_reset),
    .enable         (enable2),
    .clear_overflow (clear2),
    .dut_outputs    (dut2),
    .rd_valid       (rd_valid2),
    .rd_ready       (rd_ready2),
    .rd_value       (rd_value2),
    .rd_timestamp   (rd_timestamp2),
    .count          (count2),
    .overflow       (overflow2),
    .drop_count     (drop_count2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge hub_clocks);
    #1;
    en_ticks++;
  endtask

  task automatic drain1(input string name);
    int n = 0;
    rd_ready = 1'b1;
    while (count != 0 && n < 60) begin tick(); n++; end
    rd_ready = 1'b0;
    chk(name, 64'(count), 64'd0);
  endtask

  task automatic drain2(input string name);
    int n = 0;
    rd_ready2 = 1'b1;
    while (count2 != 0 && n < 60) begin tick(); n++; end
    rd_ready2 = 1'b0;
    chk(name, 64'(count2), 64'd0);
  endtask

  // Scoreboard monitor, instance 1.
  always @(negedge hub_clocks) begin
    logic [39:0] e;
    if (!hub_reset && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop1_unexpected: got 0x%0h, expected no entry", {rd_timestamp, rd_value});
      end else begin
        e = exp_q.pop_front();
        chk("pop1_entry", 64'({rd_timestamp, rd_value}), 64'(e));
      end
    end
  end

  // Scoreboard monitor, instance 2.
  always @(negedge hub_clocks) begin
    logic [11:0] e;
    if (!hub_reset && rd_valid2 && rd_ready2) begin
      if (exp2_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop2_unexpected: got 0x%0h, expected no entry", {rd_timestamp2, rd_value2});
      end else begin
        e = exp2_q.pop_front();
        chk("pop2_entry", 64'({rd_timestamp2, rd_value2}), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hub_reset = 1'b1;
    enable = 0; clear_overflow = 0; rd_ready = 0; dut_outputs = 8'h00;
    enable2 = 0; clear2 = 0; rd_ready2 = 0; dut2 = 8'h00;
    tick(); tick();

    // Reset state
    chk("rst_count",      64'(count), 64'd0);
    chk("rst_rd_valid",   64'(rd_valid), 64'd0);
    chk("rst_overflow",   64'(overflow), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_rd_value",   64'(rd_value), 64'd0);
    chk("rst_rd_ts",      64'(rd_timestamp), 64'd0);
    hub_reset = 1'b0;

    // Baseline only: stable 5A
    dut_outputs = 8'h5A;
    tick(); tick(); tick();
    enable = 1'b1; en_ticks = 0;
    exp_q.push_back({32'd0, 8'h5A});
    repeat (6) tick();
    chk("base_count", 64'(count), 64'd1);
    chk("base_valid", 64'(rd_valid), 64'd1);
    enable = 1'b0;
    drain1("base_drain");

    // Change at RECORD cycle 10 stamps 12
    dut_outputs = 8'h00;
    tick(); tick(); tick();
    enable = 1'b1; en_ticks = 0;
    exp_q.push_back({32'd0, 8'h00});
    repeat (11) tick();
    dut_outputs = 8'h11;
    exp_q.push_back({32'd12, 8'h11});
    repeat (5) tick();
    chk("chg_count", 64'(count), 64'd2);
    repeat (3) tick();
    chk("chg_valid_held", 64'(rd_valid), 64'd1);
    drain1("chg_drain");
    enable = 1'b0;
    tick(); tick();

    // Overflow: baseline + 20 changes into 16 entries
    dut_outputs = 8'h00;
    tick(); tick(); tick();
    enable = 1'b1; en_ticks = 0;
    exp_q.push_back({32'd0, 8'h00});
    for (int i = 0; i < 20; i++) begin
      dut_outputs = 8'(i + 1);
      if (i < 15) exp_q.push_back({32'(en_ticks + 1), 8'(i + 1)});
      tick(); tick();
    end
    tick(); tick();
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_flag",  64'(overflow), 64'd1);
    chk("ovf_drops", 64'(drop_count), 64'd5);

    // Pop coinciding with a write while full
    dut_outputs = 8'h15;
    exp_q.push_back({32'(en_ticks + 1), 8'h15});
    tick(); tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("full_pop_count", 64'(count), 64'd16);
    chk("full_pop_drops", 64'(drop_count), 64'd5);
    drain1("ovf_drain");
    enable = 1'b0;
    tick(); tick();

    // Asynchronous reset with 7 entries buffered
    dut_outputs = 8'h30;
    tick(); tick(); tick();
    enable = 1'b1; en_ticks = 0;
    for (int i = 1; i <= 6; i++) begin
      dut_outputs = 8'(8'h30 + i);
      tick(); tick();
    end
    tick(); tick();
    chk("pre_rst_count", 64'(count), 64'd7);
    #2;
    hub_reset = 1'b1;
    enable = 1'b0;
    #1;
    chk("async_rst_count",    64'(count), 64'd0);
    chk("async_rst_valid",    64'(rd_valid), 64'd0);
    chk("async_rst_overflow", 64'(overflow), 64'd0);
    chk("async_rst_drops",    64'(drop_count), 64'd0);
    tick(); tick();
    hub_reset = 1'b0;
    tick(); tick(); tick();
    enable = 1'b1; en_ticks = 0;
    exp_q.push_back({32'd0, 8'h36});
    repeat (4) tick();
    chk("rearm_count", 64'(count), 64'd1);
    drain1("rearm_drain");
    enable = 1'b0;
    tick(); tick();

    // Instance 2: timestamp wrap and clear-vs-drop
    dut2 = 8'h00;
    tick(); tick(); tick();
    enable2 = 1'b1; en_ticks = 0;
    exp2_q.push_back({4'd0, 8'h00});
    repeat (17) tick();
    dut2 = 8'hA1;
    exp2_q.push_back({4'd2, 8'hA1});
    tick(); tick(); tick();
    dut2 = 8'hA2;
    exp2_q.push_back({4'd5, 8'hA2});
    tick(); tick(); tick();
    dut2 = 8'hA3;
    exp2_q.push_back({4'd8, 8'hA3});
    tick(); tick(); tick();
    chk("w_full_count", 64'(count2), 64'd4);
    dut2 = 8'hA4;
    tick(); tick(); tick();
    chk("w_drop_flag",  64'(overflow2), 64'd1);
    chk("w_drop_count", 64'(drop_count2), 64'd1);
    clear2 = 1'b1;
    tick();
    clear2 = 1'b0;
    chk("w_clear_flag",  64'(overflow2), 64'd0);
    chk("w_clear_count", 64'(drop_count2), 64'd0);
    dut2 = 8'hA5;
    tick(); tick();
    clear2 = 1'b1;
    tick();
    clear2 = 1'b0;
    chk("w_clr_drop_flag",  64'(overflow2), 64'd1);
    chk("w_clr_drop_count", 64'(drop_count2), 64'd1);
    drain2("w_drain");
    enable2 = 1'b0;
    tick(); tick();

    chk("q1_empty", 64'(exp_q.size()), 64'd0);
    chk("q2_empty", 64'(exp2_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dut_response_recorder.md
# dut_response_recorder

Hub-clock-side capture block for the testbench: the observing counterpart of the stimulus path that drives DUT inputs. It synchronises the DUT output bus, detects every value change, time-stamps it and buffers it. A scoreboard drains the buffered events through a valid/ready read port. The block sits between the DUT outputs and the checking objects, so responses can be compared without cycle-exact polling.

## Interface
Parameters:
- DATA_WIDTH, 8, width of the DUT output bus being recorded
- DEPTH, 16, event buffer entries; power of two, ≥ 2
- TS_WIDTH, 32, timestamp width in hub_clocks cycles

Ports:
- hub_clocks  in  1  testbench hub clock; all logic on rising edge
- hub_reset  in  1  asynchronous, active-high reset
- enable  in  1  recording enable
- clear_overflow  in  1  single-cycle pulse; clears overflow and drop_count
- dut_outputs  in  DATA_WIDTH  DUT output bus; asynchronous to hub_clocks
- rd_valid  out  1  head entry available
- rd_ready  in  1  reader accepts head entry
- rd_value  out  DATA_WIDTH  recorded value of head entry
- rd_timestamp  out  TS_WIDTH  cycle stamp of head entry
- count  out  $clog2(DEPTH)+1  entries currently stored
- overflow  out  1  sticky; an event was dropped
- drop_count  out  16  dropped events, saturating at 16'hFFFF

## Operation
- Input path: 2-flop synchroniser on dut_outputs (sync1, sync2), then a `last` register holding the previous sync2 value.
- State machine:
  - IDLE: enable=0; timestamp counter held at 0; no events are written.
  - IDLE→ARMED: on enable=1.
  - ARMED: lasts exactly one cycle. Unconditionally writes {ts=0, sync2} as the baseline event, loads `last`. Goes to RECORD.
  - RECORD: when sync2≠last, writes {ts, sync2} and updates `last`. Goes to IDLE when enable=0, with no write on that cycle.
- Timestamp counter:
  - 0 in ARMED; increments by 1 every RECORD cycle.
  - Wraps from 2^TS_WIDTH−1 to 0 with no flag.
- Buffer: FIFO of {ts, value}, show-ahead. rd_value and rd_timestamp are valid whenever rd_valid=1, and are don't-care when rd_valid=0.
- Pop occurs when rd_valid && rd_ready.
- Full buffer: an event write is dropped, overflow is set, and drop_count increments (saturating).
- Full buffer with simultaneous pop: the write is accepted and count stays at DEPTH.
- Empty buffer: rd_ready is ignored.
- Simultaneous write and pop with count=0: the write lands; rd_valid rises next cycle.
- Leaving RECORD (enable→0) keeps buffered entries; the reader can drain them while in IDLE.
- clear_overflow in the same cycle as a drop: the drop wins. overflow=1, drop_count=1.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE; sync1, sync2, last, ts all 0
  - count 0, rd_valid 0, overflow 0, drop_count 0
  - rd_value 0, rd_timestamp 0
- Latency: a change sampled by sync1 at edge k is written at edge k+2. rd_valid is high after edge k+2 if the FIFO was empty.
- Enable rising at edge e: ARMED during cycle e+1; the baseline is written at edge e+2.
- Reset asserted mid-operation: all buffered entries are lost and the state returns to IDLE. The first write after release is the ARMED baseline.
- Changes that last fewer than 1 hub cycle may be missed. Only the value present at each sampling edge is recorded.

## Structure
- recorder_pkg:
  - typedef rec_entry_t {ts, value}, parameterised through the module's localparams or a class-free struct macro
  - state enum rec_state_t {IDLE, ARMED, RECORD}
- Sub-module recorder_fifo:
  - synchronous show-ahead FIFO with push, pop, full, empty, count
  - pointers one bit wider than $clog2(DEPTH) so that full and empty are distinguished on wrap
- Top level holds the synchroniser, FSM, timestamp counter and overflow logic.

## Test plan
- Reset, enable=1, dut_outputs=8'h5A stable → exactly one entry {ts=0, 8'h5A}; count=1.
- Enable, then change dut_outputs 8'h00→8'h11 at RECORD cycle 10 → second entry 8'h11 with ts=10+2 (synchroniser delay). rd_valid stays high until rd_ready pops both entries.
- DEPTH=16, rd_ready=0, 20 changes → count=16; overflow=1; drop_count=5 (baseline + 15 kept). Pop one while a change arrives → count remains 16, drop_count unchanged.
- Assert hub_reset with 7 entries buffered → count=0, rd_valid=0, overflow=0 immediately, asynchronously to hub_clocks. Re-enable → new baseline with ts=0.
- TS_WIDTH=4, 20 constant-then-change cycles → entry ts wraps (e.g. cycle 18 stamps 2). clear_overflow together with a drop → overflow=1, drop_count=1.
